program_cache: RTL
==================

// Module: program_cache
// PURPOSE
//  Direct-mapped, read-only instruction cache between the RIPTIDE-II fetch port (A/I/p_cache_miss)
//  and the SDRAM controller's burst read port. Returns I one cycle after A on a hit. On a miss it
//  holds p_cache_miss high, fetches one full line from SDRAM, then resumes.
// PARAMETERS
//  LINE_BITS   3  log2(words per line); 8 x 16-bit words per line
//  INDEX_BITS  6  log2(line count); 64 lines = 512 words; TAG = 16-INDEX_BITS-LINE_BITS bits
// PORTS
//  clk           in   1   core clock; all logic on rising edge
//  RST           in   1   asynchronous, active-high reset
//  A             in   16  program word address from PC
//  I             out  16  instruction word for address registered last cycle
//  p_cache_miss  out  1   high: I invalid, core stalls and holds A
//  flush         in   1   one-cycle pulse: invalidate all lines
//  mem_req       out  1   line-fill request to SDRAM controller
//  mem_addr      out  16  line base word address {tag,index,LINE_BITS'b0}
//  mem_ack       in   1   one-cycle accept of mem_req
//  mem_rd_valid  in   1   qualifies mem_data; exactly 2**LINE_BITS beats per fill, ascending order
//  mem_data      in   16  fill data
// BEHAVIOUR
//  - Storage: data RAM (synchronous read, 1R1W), tag RAM, valid bits in flops (cleared by RST/flush).
//  - A_q captures A each cycle while state==IDLE and p_cache_miss==0; held otherwise.
//  - RAM read address = A when (IDLE & ~p_cache_miss), else A_q. I = RAM output.
//  - p_cache_miss = (state!=IDLE) | ~valid[idx(A_q)] | (tag[idx(A_q)]!=tag(A_q)).
//  - Hit latency 1 cycle: A presented cycle n -> I valid cycle n+1.
//  - FSM:
//    - IDLE: miss -> REQ.
//    - REQ: mem_req=1, mem_addr stable = line base of A_q; mem_ack -> FILL.
//    - FILL: each mem_rd_valid writes word cnt, cnt++. The last beat writes tag, sets valid
//      (unless flush_pend) -> RESTART.
//    - RESTART: one cycle, re-reads A_q -> IDLE.
//  - Beat counter wraps to 0 after the last beat. Gaps between beats allowed; beats outside FILL ignored.
//  - mem_req drops the cycle after mem_ack is sampled. mem_ack outside REQ is ignored.
//  - flush in IDLE: all valid=0 next cycle. If a hit was pending, next-cycle miss is allowed.
//  - flush during REQ/FILL/RESTART: valid bits cleared; flush_pend set; the fill completes, but its
//    line is NOT validated. flush_pend clears on RESTART exit. The core therefore misses and refetches.
//  - flush coincident with the last beat: flush wins; line stays invalid.
//  - A changes while p_cache_miss=1: ignored; the refill always uses A_q.
//  - RST mid-fill: FSM->IDLE, cnt=0, valid all 0. Remaining SDRAM beats are ignored, since FSM≠FILL.
//  - Reset values: I=16'h0000, mem_req=0, mem_addr=16'h0000, A_q=0, state=IDLE, flush_pend=0.
//    p_cache_miss=1, since valid=0, so fetch of address 0 misses immediately after reset.
// CONFIGURATION
//  PCACHE_STATS_EN defined:
//    - adds outputs hit_count[15:0] and miss_count[15:0].
//    - hit_count: +1 per IDLE cycle with a hit. miss_count: +1 per IDLE->REQ transition.
//    - Both saturate at 16'hFFFF; cleared by RST and flush.
//  PCACHE_STATS_EN undefined: the ports and counters are absent; behaviour is otherwise identical.
// TESTING
//  1. Release RST, A=0x0000 -> p_cache_miss=1, mem_req=1, mem_addr=0x0000. Send ack + 8 beats
//     0x1000..0x1007 -> after RESTART, I=0x1000, miss=0.
//  2. Following 1, A=0x0001..0x0007 on consecutive cycles -> I=0x1001..0x1007, one per cycle,
//     miss stays 0, no mem_req.
//  3. A=0x0200 (same index 0, new tag) -> miss. Refill, then A=0x0000 -> miss again:
//     mem_addr=0x0000, conflict eviction.
//  4. flush on the same cycle as the 8th beat of fill for 0x0040 -> line not valid; core re-requests
//     0x0040 after RESTART.
//  5. RST asserted after 3 beats of a fill -> mem_req=0 immediately. Remaining beats are ignored.
//     After release, A=0x0000 misses.
//  6. (PCACHE_STATS_EN) scenario 1+2 -> miss_count=1, hit_count=8. Then flush -> both 0.

Source files
------------

// File: rtl/program_cache.sv
// Direct-mapped read-only instruction cache with single-line SDRAM burst refill.
// Optional hit/miss statistics counters are enabled by defining PCACHE_STATS_EN.
module program_cache #(
    parameter int LINE_BITS  = 3,
    parameter int INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [15:0] A,
    output logic [15:0] I,
    output logic        p_cache_miss,
    input  logic        flush,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic        mem_rd_valid,
`ifdef PCACHE_STATS_EN
    output logic [15:0] hit_count,
    output logic [15:0] miss_count,
`endif
    input  logic [15:0] mem_data
);

    localparam int TAG_BITS  = 16 - INDEX_BITS - LINE_BITS;
    localparam int LINES     = 1 << INDEX_BITS;
    localparam int WORDS     = 1 << (INDEX_BITS + LINE_BITS);
    localparam int WADDR_W   = INDEX_BITS + LINE_BITS;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL,
        RESTART
    } state_t;

    state_t state;
    state_t state_next;

    logic [15:0]           a_q;
    logic [LINE_BITS-1:0]  cnt;
    logic                  flush_pend;
    logic [LINES-1:0]      valid;
    logic [TAG_BITS-1:0]   tag_ram  [LINES];
    logic [15:0]           data_ram [WORDS];

    logic [INDEX_BITS-1:0] q_index;
    logic [TAG_BITS-1:0]   q_tag;
    logic                  idle;
    logic                  hit;
    logic                  capture;
    logic                  beat;
    logic                  last_beat;
    logic [WADDR_W-1:0]    rd_addr;
    logic [WADDR_W-1:0]    wr_addr;

    assign q_index      = a_q[LINE_BITS +: INDEX_BITS];
    assign q_tag        = a_q[15 -: TAG_BITS];
    assign idle         = (state == IDLE);
    assign hit          = valid[q_index] && (tag_ram[q_index] == q_tag);
    assign capture      = idle && hit;
    assign p_cache_miss = !capture;
    assign beat         = (state == FILL) && mem_rd_valid;
    assign last_beat    = beat && (cnt == '1);

    // While stalled the RAM keeps re-reading the held address so I is ready on resume.
    assign rd_addr  = capture ? A[WADDR_W-1:0] : a_q[WADDR_W-1:0];
    assign wr_addr  = {q_index, cnt};
    assign mem_req  = (state == REQ);
    assign mem_addr = {a_q[15:LINE_BITS], {LINE_BITS{1'b0}}};

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!hit) state_next = REQ;
            REQ:     if (mem_ack) state_next = FILL;
            FILL:    if (last_beat) state_next = RESTART;
            RESTART: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A flush seen while a fill is in flight must keep that line from being validated.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            a_q        <= 16'h0000;
            cnt        <= '0;
            flush_pend <= 1'b0;
            valid      <= '0;
            I          <= 16'h0000;
        end else begin
            if (capture) begin
                a_q <= A;
            end
            I <= data_ram[rd_addr];
            if (beat) begin
                cnt <= cnt + 1'b1;
            end
            if (state == RESTART) begin
                flush_pend <= 1'b0;
            end else if (flush && !idle) begin
                flush_pend <= 1'b1;
            end
            if (flush) begin
                valid <= '0;
            end else if (last_beat && !flush_pend) begin
                valid[q_index] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (beat) begin
            data_ram[wr_addr] <= mem_data;
        end
        if (last_beat) begin
            tag_ram[q_index] <= q_tag;
        end
    end

`ifdef PCACHE_STATS_EN
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            hit_count  <= 16'h0000;
            miss_count <= 16'h0000;
        end else if (flush) begin
            hit_count  <= 16'h0000;
            miss_count <= 16'h0000;
        end else begin
            if (capture && (hit_count != 16'hFFFF)) begin
                hit_count <= hit_count + 16'd1;
            end
            if (idle && !hit && (miss_count != 16'hFFFF)) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif

endmodule
